// File: rtl/la132_pkg.sv
// Shared definitions for the LA132 multicycle core: FSM states and the
// opcode field values recognised by the decoder.
package la132_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  // inst[31:15]
  localparam logic [16:0] OP_ADD  = 17'h00020;
  localparam logic [16:0] OP_SUB  = 17'h00022;
  localparam logic [16:0] OP_AND  = 17'h00029;
  localparam logic [16:0] OP_OR   = 17'h0002A;
  localparam logic [16:0] OP_XOR  = 17'h0002B;
  localparam logic [16:0] OP_IDLE = 17'h00C91;

  // inst[31:22]
  localparam logic [9:0] OP_ADDI = 10'h00A;
  localparam logic [9:0] OP_LDW  = 10'h0A2;
  localparam logic [9:0] OP_STW  = 10'h0A6;

  // inst[31:25]
  localparam logic [6:0] OP_LU12I = 7'h0A;

  // inst[31:26]
  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/la132_regfile.sv
// 32x32 general-purpose register file: two asynchronous read ports, one
// synchronous write port, r0 hardwired to zero.
module la132_regfile
  import la132_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/la132_top.sv
// LA132: non-pipelined multicycle LA32R-subset core with separate
// instruction and data SRAM request/ready interfaces and a retire trace.
module la132_top
  import la132_pkg::*;
(
  input  logic        clk,
  input  logic        hard_reset,
  input  logic [31:0] boot_pc,
  input  logic [31:0] inst_xor,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        inst_sram_rrdy,
  output logic        data_sram_en,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_strb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_rrdy,
  output logic [31:0] cpu_fetch_pc,
  output logic        sleeping,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_rf_dest,
  output logic        wb_rf_wen,
  output logic [31:0] wb_rf_value
);

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] inst;

  logic [31:0] next_pc_q;
  logic        rf_wen_q;
  logic [4:0]  rf_dest_q;
  logic [31:0] rf_value_q;
  logic        idle_q;
  logic        mem_wr_q;
  logic [3:0]  mem_strb_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [16:0] op17;
  logic [9:0]  op10;
  logic [6:0]  op7;
  logic [5:0]  op6;
  logic [4:0]  ra2;
  logic [31:0] rj_val, rf_rd2;
  logic [31:0] off16, off26, pc_plus4;

  logic        ex_wen, ex_mem, ex_mem_wr, ex_idle;
  logic [4:0]  ex_dest;
  logic [31:0] ex_value, ex_next_pc, ex_addr;

  assign op17     = inst[31:15];
  assign op10     = inst[31:22];
  assign op7      = inst[31:25];
  assign op6      = inst[31:26];
  assign off16    = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign off26    = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  assign pc_plus4 = pc + 32'd4;

  // Second read port carries rd for compare-branches and store data, rk otherwise.
  assign ra2 = ((op6 == OP_BEQ) || (op6 == OP_BNE) || (op10 == OP_STW)) ? inst[4:0] : inst[14:10];

  la132_regfile u_regfile (
    .clk (clk),
    .rst (hard_reset),
    .ra1 (inst[9:5]),
    .ra2 (ra2),
    .rd1 (rj_val),
    .rd2 (rf_rd2),
    .we  ((state == S_WB) && rf_wen_q),
    .wa  (rf_dest_q),
    .wd  (rf_value_q)
  );

  always_comb begin
    ex_wen     = 1'b0;
    ex_dest    = inst[4:0];
    ex_value   = '0;
    ex_next_pc = pc_plus4;
    ex_mem     = 1'b0;
    ex_mem_wr  = 1'b0;
    ex_idle    = 1'b0;
    ex_addr    = rj_val + sext12(inst[21:10]);
    if (op17 == OP_ADD) begin
      ex_wen = 1'b1; ex_value = rj_val + rf_rd2;
    end else if (op17 == OP_SUB) begin
      ex_wen = 1'b1; ex_value = rj_val - rf_rd2;
    end else if (op17 == OP_AND) begin
      ex_wen = 1'b1; ex_value = rj_val & rf_rd2;
    end else if (op17 == OP_OR) begin
      ex_wen = 1'b1; ex_value = rj_val | rf_rd2;
    end else if (op17 == OP_XOR) begin
      ex_wen = 1'b1; ex_value = rj_val ^ rf_rd2;
    end else if (op17 == OP_IDLE) begin
      ex_idle = 1'b1;
    end else if (op10 == OP_ADDI) begin
      ex_wen = 1'b1; ex_value = ex_addr;
    end else if (op10 == OP_LDW) begin
      ex_wen = 1'b1; ex_mem = 1'b1;
    end else if (op10 == OP_STW) begin
      ex_mem = 1'b1; ex_mem_wr = 1'b1;
    end else if (op7 == OP_LU12I) begin
      ex_wen = 1'b1; ex_value = {inst[24:5], 12'b0};
    end else if (op6 == OP_JIRL) begin
      ex_wen = 1'b1; ex_value = pc_plus4; ex_next_pc = rj_val + off16;
    end else if (op6 == OP_B) begin
      ex_next_pc = pc + off26;
    end else if (op6 == OP_BL) begin
      ex_wen = 1'b1; ex_dest = 5'd1; ex_value = pc_plus4; ex_next_pc = pc + off26;
    end else if (op6 == OP_BEQ) begin
      if (rj_val == rf_rd2) ex_next_pc = pc + off16;
    end else if (op6 == OP_BNE) begin
      if (rj_val != rf_rd2) ex_next_pc = pc + off16;
    end
    if (ex_dest == 5'd0) ex_wen = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (inst_sram_rrdy) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = ex_mem ? S_MEM : S_WB;
      S_MEM:   if (data_sram_rrdy) state_nxt = S_WB;
      S_WB:    state_nxt = idle_q ? S_HALT : S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      state       <= S_FETCH;
      pc          <= boot_pc;
      inst        <= '0;
      next_pc_q   <= '0;
      rf_wen_q    <= 1'b0;
      rf_dest_q   <= '0;
      rf_value_q  <= '0;
      idle_q      <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_strb_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: if (inst_sram_rrdy) inst <= inst_sram_rdata ^ inst_xor;
        S_EXEC: begin
          rf_wen_q    <= ex_wen;
          rf_dest_q   <= ex_dest;
          rf_value_q  <= ex_value;
          next_pc_q   <= ex_next_pc;
          idle_q      <= ex_idle;
          mem_wr_q    <= ex_mem_wr;
          mem_strb_q  <= ex_mem_wr ? 4'hF : 4'h0;
          mem_addr_q  <= ex_addr;
          mem_wdata_q <= rf_rd2;
        end
        S_MEM: if (data_sram_rrdy && !mem_wr_q) rf_value_q <= data_sram_rdata;
        S_WB: pc <= next_pc_q;
        default: ;
      endcase
    end
  end

  // Requests are masked during reset so an abandoned transfer is never re-presented.
  assign inst_sram_en    = (state == S_FETCH) && !hard_reset;
  assign inst_sram_addr  = pc;
  assign data_sram_en    = (state == S_MEM) && !hard_reset;
  assign data_sram_wr    = mem_wr_q;
  assign data_sram_strb  = mem_strb_q;
  assign data_sram_addr  = mem_addr_q;
  assign data_sram_wdata = mem_wdata_q;
  assign cpu_fetch_pc    = pc;
  assign sleeping        = (state == S_HALT);
  assign wb_pc           = (state == S_WB) ? pc : '0;
  assign wb_rf_wen       = (state == S_WB) && rf_wen_q;
  assign wb_rf_dest      = wb_rf_wen ? rf_dest_q : '0;
  assign wb_rf_value     = wb_rf_wen ? rf_value_q : '0;

endmodule

// File: tb/tb_la132_top.sv
// Bench for la132_top: SRAM responders with random latency, an
// instruction-level reference model and a retire/data-request scoreboard.
module tb_la132_top;

  logic        clk = 1'b0;
  logic        hard_reset = 1'b1;
  logic [31:0] boot_pc = 32'h1C00_0000;
  logic [31:0] inst_xor = '0;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = '0;
  logic        inst_sram_rrdy = 1'b0;
  logic        data_sram_en, data_sram_wr;
  logic [3:0]  data_sram_strb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [31:0] data_sram_rdata = '0;
  logic        data_sram_rrdy = 1'b0;
  logic [31:0] cpu_fetch_pc;
  logic        sleeping;
  logic [31:0] wb_pc;
  logic [4:0]  wb_rf_dest;
  logic        wb_rf_wen;
  logic [31:0] wb_rf_value;

  la132_top dut (
    .clk(clk), .hard_reset(hard_reset), .boot_pc(boot_pc), .inst_xor(inst_xor),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .inst_sram_rrdy(inst_sram_rrdy),
    .data_sram_en(data_sram_en), .data_sram_wr(data_sram_wr), .data_sram_strb(data_sram_strb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .data_sram_rrdy(data_sram_rrdy),
    .cpu_fetch_pc(cpu_fetch_pc), .sleeping(sleeping), .wb_pc(wb_pc),
    .wb_rf_dest(wb_rf_dest), .wb_rf_wen(wb_rf_wen), .wb_rf_value(wb_rf_value)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic wen; logic [4:0] dest; logic [31:0] val;} trace_t;
  typedef struct {logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb;} dreq_t;

  trace_t      tq[$];
  dreq_t       dq[$];
  logic [31:0] prog [logic [31:0]];
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];
  logic [31:0] mreg [32];
  logic [31:0] mpc;
  bit          mhalt = 1'b1;
  bit          random_gen = 1'b0;
  bit          stall_fetch = 1'b0;
  bit          late_rrdy = 1'b0;
  int          retired = 0;
  int          vectors = 0;
  int          miscompares = 0;

  localparam logic [31:0] BASE = 32'h1C00_0000;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [16:0] op, input logic [4:0] rd, rj, rk);
    return {op, rk, rj, rd};
  endfunction
  function automatic logic [31:0] enc_i12(input logic [9:0] op, input logic [4:0] rd, rj, input logic [11:0] si);
    return {op, si, rj, rd};
  endfunction
  function automatic logic [31:0] enc_lu12i(input logic [4:0] rd, input logic [19:0] si);
    return {7'h0A, si, rd};
  endfunction
  function automatic logic [31:0] enc_b16(input logic [5:0] op, input logic [4:0] rd, rj, input int off);
    int q;
    logic [31:0] qv;
    q = off / 4;
    qv = q;
    return {op, qv[15:0], rj, rd};
  endfunction
  function automatic logic [31:0] enc_b26(input logic [5:0] op, input int off);
    int q;
    logic [31:0] qv;
    q = off / 4;
    qv = q;
    return {op, qv[15:0], qv[25:16]};
  endfunction
  localparam logic [31:0] IDLE_W = {17'h00C91, 15'h0};

  function automatic logic [31:0] gen_inst();
    logic [4:0] rd, rj, rk;
    int off;
    rd = 5'($urandom_range(0, 31));
    rj = 5'($urandom_range(0, 31));
    rk = 5'($urandom_range(0, 31));
    off = ($urandom_range(0, 1) == 1 ? -1 : 1) * int'($urandom_range(1, 6)) * 4;
    case ($urandom_range(0, 13))
      0:  return enc_r(17'h20, rd, rj, rk);
      1:  return enc_r(17'h22, rd, rj, rk);
      2:  return enc_r(17'h29, rd, rj, rk);
      3:  return enc_r(17'h2A, rd, rj, rk);
      4:  return enc_r(17'h2B, rd, rj, rk);
      5, 6: return enc_i12(10'h00A, rd, rj, 12'($urandom));
      7:  return enc_lu12i(rd, 20'($urandom));
      8:  return enc_i12(10'h0A2, rd, rj, 12'($urandom));
      9:  return enc_i12(10'h0A6, rd, rj, 12'($urandom));
      10: return enc_b16(6'h16, rd, rj, off);
      11: return enc_b16(6'h17, rd, rj, off);
      12: return enc_b26($urandom_range(0, 1) == 1 ? 6'h15 : 6'h14, int'($urandom_range(1, 6)) * 4);
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  // Reference model: executes one instruction at the ISA level.
  task automatic model_exec(input logic [31:0] pc, input logic [31:0] raw);
    logic [31:0] w, vj, vk, vd, val, nxt, addr;
    logic [4:0]  dst;
    bit          wr;
    int          s12, o16, o26;
    trace_t      t;
    dreq_t       d;
    w   = raw ^ inst_xor;
    dst = w[4:0];
    vj  = mreg[w[9:5]];
    vk  = mreg[w[14:10]];
    vd  = mreg[w[4:0]];
    s12 = int'(w[21:10]);           if (s12 >= 2048) s12 -= 4096;
    o16 = int'(w[25:10]);           if (o16 >= 32768) o16 -= 65536;
    o26 = int'({w[9:0], w[25:10]}); if (o26 >= 33554432) o26 -= 67108864;
    o16 = o16 * 4;
    o26 = o26 * 4;
    addr = vj + s12;
    nxt = pc + 4;
    wr  = 1'b0;
    val = '0;
    if      (w[31:15] == 17'h20) begin wr = 1; val = vj + vk; end
    else if (w[31:15] == 17'h22) begin wr = 1; val = vj - vk; end
    else if (w[31:15] == 17'h29) begin wr = 1; val = vj & vk; end
    else if (w[31:15] == 17'h2A) begin wr = 1; val = vj | vk; end
    else if (w[31:15] == 17'h2B) begin wr = 1; val = vj ^ vk; end
    else if (w[31:15] == 17'hC91) mhalt = 1'b1;
    else if (w[31:22] == 10'h00A) begin wr = 1; val = addr; end
    else if (w[31:22] == 10'h0A2) begin
      wr = 1;
      val = mmem.exists(addr) ? mmem[addr] : mem_default(addr);
      d = '{addr: addr, wr: 1'b0, wdata: '0, strb: 4'h0};
      dq.push_back(d);
    end else if (w[31:22] == 10'h0A6) begin
      mmem[addr] = vd;
      d = '{addr: addr, wr: 1'b1, wdata: vd, strb: 4'hF};
      dq.push_back(d);
    end
    else if (w[31:25] == 7'h0A) begin wr = 1; val = {w[24:5], 12'h000}; end
    else if (w[31:26] == 6'h13) begin wr = 1; val = pc + 4; nxt = vj + o16; end
    else if (w[31:26] == 6'h14) nxt = pc + o26;
    else if (w[31:26] == 6'h15) begin wr = 1; dst = 5'd1; val = pc + 4; nxt = pc + o26; end
    else if (w[31:26] == 6'h16) begin if (vj == vd) nxt = pc + o16; end
    else if (w[31:26] == 6'h17) begin if (vj != vd) nxt = pc + o16; end
    t.pc   = pc;
    t.wen  = wr && (dst != 5'd0);
    t.dest = t.wen ? dst : 5'd0;
    t.val  = t.wen ? val : 32'd0;
    tq.push_back(t);
    if (t.wen) mreg[dst] = val;
    mpc = nxt;
  endtask

  // Instruction SRAM responder
  initial begin
    int unsigned ilat;
    bit          prev_en;
    logic [31:0] last_addr, a;
    ilat = 0;
    prev_en = 1'b0;
    last_addr = '0;
    forever begin
      @(negedge clk);
      inst_sram_rrdy = hard_reset && late_rrdy;
      if (hard_reset) begin
        prev_en = 1'b0;
        continue;
      end
      if (mhalt) check1("halt_no_fetch", inst_sram_en, 1'b0);
      if (inst_sram_en && !mhalt) begin
        if (prev_en) check32("fetch_addr_stable", inst_sram_addr, last_addr);
        last_addr = inst_sram_addr;
        prev_en = 1'b1;
        if (!stall_fetch) begin
          if (ilat == 0) begin
            check32("fetch_addr", inst_sram_addr, mpc);
            check32("cpu_fetch_pc", cpu_fetch_pc, mpc);
            a = mpc;
            if (!prog.exists(a)) prog[a] = (random_gen ? gen_inst() : 32'hFC00_0000) ^ inst_xor;
            inst_sram_rdata = prog[a];
            inst_sram_rrdy = 1'b1;
            model_exec(a, prog[a]);
            prev_en = 1'b0;
            ilat = $urandom_range(0, 2);
          end else begin
            ilat--;
          end
        end
      end else begin
        prev_en = 1'b0;
      end
    end
  end

  // Data SRAM responder
  initial begin
    int unsigned dlat;
    bit          prev_en;
    dreq_t       last, e;
    dlat = 0;
    prev_en = 1'b0;
    last = '{addr: '0, wr: 1'b0, wdata: '0, strb: '0};
    forever begin
      @(negedge clk);
      data_sram_rrdy = 1'b0;
      if (hard_reset) begin
        prev_en = 1'b0;
        continue;
      end
      if (mhalt) check1("halt_no_data", data_sram_en, 1'b0);
      if (data_sram_en && !mhalt) begin
        if (prev_en) begin
          check32("daddr_stable", data_sram_addr, last.addr);
          check32("dwdata_stable", data_sram_wdata, last.wdata);
          check1("dwr_stable", data_sram_wr, last.wr);
          check32("dstrb_stable", 32'(data_sram_strb), 32'(last.strb));
        end
        last = '{addr: data_sram_addr, wr: data_sram_wr, wdata: data_sram_wdata, strb: data_sram_strb};
        prev_en = 1'b1;
        if (dlat == 0) begin
          vectors++;
          if (dq.size() == 0) begin
            miscompares++;
            $display("FAIL data_unexpected: got request at %h expected none", data_sram_addr);
          end else begin
            e = dq.pop_front();
            check32("data_addr", data_sram_addr, e.addr);
            check1("data_wr", data_sram_wr, e.wr);
            check32("data_strb", 32'(data_sram_strb), 32'(e.strb));
            if (e.wr) check32("data_wdata", data_sram_wdata, e.wdata);
          end
          if (data_sram_wr) dmem[data_sram_addr] = data_sram_wdata;
          else data_sram_rdata = dmem.exists(data_sram_addr) ? dmem[data_sram_addr] : mem_default(data_sram_addr);
          data_sram_rrdy = 1'b1;
          prev_en = 1'b0;
          dlat = $urandom_range(0, 2);
        end else begin
          dlat--;
        end
      end else begin
        prev_en = 1'b0;
      end
    end
  end

  // Retire monitor
  initial begin
    trace_t e;
    forever begin
      @(negedge clk);
      if (!hard_reset && wb_pc !== 32'd0) begin
        retired++;
        if (tq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL trace_unexpected: got retire at %h expected none", wb_pc);
        end else begin
          e = tq.pop_front();
          check32("wb_pc", wb_pc, e.pc);
          check1("wb_rf_wen", wb_rf_wen, e.wen);
          check32("wb_rf_dest", 32'(wb_rf_dest), 32'(e.dest));
          check32("wb_rf_value", wb_rf_value, e.val);
        end
      end
    end
  end

  task automatic do_reset(input logic [31:0] boot, input bit late, input bit stall);
    @(posedge clk); #1;
    hard_reset = 1'b1;
    late_rrdy = late;
    stall_fetch = stall;
    boot_pc = boot;
    @(posedge clk); #1;
    tq.delete();
    dq.delete();
    mmem.delete();
    dmem.delete();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mpc = boot;
    mhalt = 1'b0;
    retired = 0;
    check1("rst_inst_en", inst_sram_en, 1'b0);
    check1("rst_data_en", data_sram_en, 1'b0);
    check1("rst_sleeping", sleeping, 1'b0);
    check32("rst_wb_pc", wb_pc, 32'd0);
    check1("rst_wb_wen", wb_rf_wen, 1'b0);
    check32("rst_pc", cpu_fetch_pc, boot);
    hard_reset = 1'b0;
    late_rrdy = 1'b0;
    #1;
    check1("first_fetch_en", inst_sram_en, 1'b1);
    check32("first_fetch_addr", inst_sram_addr, boot);
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 3000 && !(mhalt && tq.size() == 0 && sleeping); i++) @(negedge clk);
    @(posedge clk); #1;
    check1("halt_sleeping", sleeping, 1'b1);
    check32("halt_pc", cpu_fetch_pc, mpc);
    check32("halt_trace_drained", tq.size(), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    // Directed program: arithmetic, LU12I/ST/LD, branches, r0 write, NOP, IDLE
    prog[BASE + 32'h00] = enc_i12(10'h00A, 5'd1, 5'd0, 12'd5);
    prog[BASE + 32'h04] = enc_r(17'h20, 5'd2, 5'd1, 5'd1);
    prog[BASE + 32'h08] = enc_lu12i(5'd3, 20'h12345);
    prog[BASE + 32'h0C] = enc_i12(10'h0A6, 5'd3, 5'd0, 12'h010);
    prog[BASE + 32'h10] = enc_i12(10'h0A2, 5'd4, 5'd0, 12'h010);
    prog[BASE + 32'h14] = enc_b16(6'h16, 5'd0, 5'd0, 8);
    prog[BASE + 32'h18] = enc_b26(6'h14, 16);
    prog[BASE + 32'h1C] = enc_b26(6'h15, -4);
    prog[BASE + 32'h28] = enc_i12(10'h00A, 5'd0, 5'd0, 12'd7);
    prog[BASE + 32'h2C] = enc_b16(6'h17, 5'd0, 5'd1, 8);
    prog[BASE + 32'h30] = IDLE_W;
    prog[BASE + 32'h34] = enc_b16(6'h13, 5'd6, 5'd1, 32'h20);
    prog[BASE + 32'h40] = enc_r(17'h22, 5'd7, 5'd2, 5'd1);
    prog[BASE + 32'h44] = enc_i12(10'h00A, 5'd8, 5'd2, 12'hFFD);
    prog[BASE + 32'h48] = enc_r(17'h2B, 5'd9, 5'd8, 5'd2);
    prog[BASE + 32'h4C] = 32'hFFFF_FFFF;
    prog[BASE + 32'h50] = IDLE_W;
    do_reset(BASE, 1'b0, 1'b0);
    wait_halt();

    // Inverted encodings, BEQ at the boot address
    prog.delete();
    inst_xor = 32'hFFFF_FFFF;
    prog[BASE + 32'h00] = enc_b16(6'h16, 5'd0, 5'd0, 8) ^ inst_xor;
    prog[BASE + 32'h08] = enc_i12(10'h00A, 5'd1, 5'd0, 12'd5) ^ inst_xor;
    prog[BASE + 32'h0C] = IDLE_W ^ inst_xor;
    do_reset(BASE, 1'b0, 1'b0);
    wait_halt();

    // Fetch stall, then reset with a late ready during the reset cycle
    prog.delete();
    inst_xor = '0;
    prog[BASE + 32'h00] = enc_i12(10'h00A, 5'd1, 5'd0, 12'd5);
    prog[BASE + 32'h04] = IDLE_W;
    do_reset(BASE, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check1("stall_en", inst_sram_en, 1'b1);
      check32("stall_addr", inst_sram_addr, BASE);
    end
    do_reset(BASE, 1'b1, 1'b0);
    wait_halt();

    // Randomized instruction streams
    for (int r = 0; r < 3; r++) begin
      prog.delete();
      random_gen = 1'b1;
      inst_xor = $urandom;
      do_reset(BASE, 1'b0, 1'b0);
      for (int c = 0; c < 20000 && retired < 200; c++) @(negedge clk);
      check1("random_progress", retired >= 200, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
